// File: rtl/stack_access_if.sv
// Request/response and Stack-side signals of the stack access controller.
// master = requesters plus Stack (environment side), slave = controller.
interface stack_access_if #(
   parameter int CW = 6
);
   logic          r0_valid;
   logic          r0_op;
   logic          r0_word;
   logic [15:0]   r0_wdata;
   logic          r0_done;
   logic          r0_err;
   logic          r1_valid;
   logic          r1_op;
   logic          r1_word;
   logic [15:0]   r1_wdata;
   logic          r1_done;
   logic          r1_err;
   logic [15:0]   rdata;
   logic          stk_push;
   logic          stk_pop;
   logic [7:0]    stk_din;
   logic [7:0]    stk_dout;
   logic          busy;
   logic [CW-1:0] count;

   modport master (
      output r0_valid, r0_op, r0_word, r0_wdata,
      output r1_valid, r1_op, r1_word, r1_wdata,
      output stk_dout,
      input  r0_done, r0_err, r1_done, r1_err, rdata,
      input  stk_push, stk_pop, stk_din, busy, count
   );

   modport slave (
      input  r0_valid, r0_op, r0_word, r0_wdata,
      input  r1_valid, r1_op, r1_word, r1_wdata,
      input  stk_dout,
      output r0_done, r0_err, r1_done, r1_err, rdata,
      output stk_push, stk_pop, stk_din, busy, count
   );
endinterface

// File: rtl/stack_access_ctrl.sv
// Round-robin arbiter and byte/word sequencer in front of an 8-bit hardware Stack.
// Keeps its own occupancy count so overflow/underflow is rejected before any Stack access.
module stack_access_ctrl #(
   parameter int DEPTH = 32,
   parameter int CW    = 6
) (
   input logic           clk,
   input logic           rst,
   stack_access_if.slave bus
);
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      PUSH_LO = 3'd1,
      PUSH_HI = 3'd2,
      POP_HI  = 3'd3,
      POP_LO  = 3'd4,
      CAPTURE = 3'd5,
      RESP    = 3'd6
   } state_t;

   localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

   state_t        state_r, state_nxt_s;
   logic          id_r, op_r, word_r, err_r, last_gnt_r;
   logic [15:0]   wdata_r, rdata_r;
   logic [CW-1:0] count_r;
   logic          stk_push_r, stk_pop_r, busy_r;
   logic [7:0]    stk_din_r;
   logic          r0_done_r, r1_done_r, r0_err_r, r1_err_r;

   logic          gnt_valid_s, gnt_id_s;
   logic          req_op_s, req_word_s;
   logic [15:0]   req_wdata_s, cur_wdata_s;
   logic          cur_id_s, err_nxt_s;
   logic [CW:0]   need_s;
   logic          cap_ok_s;

   // Arbitration: on a tie the requester other than last_gnt wins.
   always_comb begin
      gnt_valid_s = 1'b0;
      gnt_id_s    = 1'b0;
      if (bus.r0_valid && bus.r1_valid) begin
         gnt_valid_s = 1'b1;
         gnt_id_s    = ~last_gnt_r;
      end else if (bus.r0_valid) begin
         gnt_valid_s = 1'b1;
         gnt_id_s    = 1'b0;
      end else if (bus.r1_valid) begin
         gnt_valid_s = 1'b1;
         gnt_id_s    = 1'b1;
      end else begin
         gnt_valid_s = 1'b0;
         gnt_id_s    = 1'b0;
      end
   end

   // Winner's fields and the capacity check against the registered count.
   always_comb begin
      req_op_s    = gnt_id_s ? bus.r1_op    : bus.r0_op;
      req_word_s  = gnt_id_s ? bus.r1_word  : bus.r0_word;
      req_wdata_s = gnt_id_s ? bus.r1_wdata : bus.r0_wdata;
      need_s      = req_word_s ? (CW+1)'(2) : (CW+1)'(1);
      if (req_op_s) begin
         cap_ok_s = ({1'b0, count_r} >= need_s);
      end else begin
         cap_ok_s = (({1'b0, count_r} + need_s) <= DEPTH_W);
      end
   end

   // Next-state logic; fields come from the inputs in IDLE and from the latches afterwards.
   always_comb begin
      state_nxt_s = state_r;
      err_nxt_s   = err_r;
      cur_id_s    = (state_r == IDLE) ? gnt_id_s : id_r;
      cur_wdata_s = (state_r == IDLE) ? req_wdata_s : wdata_r;
      case (state_r)
         IDLE: begin
            if (gnt_valid_s && cap_ok_s) begin
               err_nxt_s = 1'b0;
               if (req_op_s) begin
                  state_nxt_s = req_word_s ? POP_HI : POP_LO;
               end else begin
                  state_nxt_s = PUSH_LO;
               end
            end else if (gnt_valid_s) begin
               err_nxt_s   = 1'b1;
               state_nxt_s = RESP;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         PUSH_LO: state_nxt_s = word_r ? PUSH_HI : RESP;
         PUSH_HI: state_nxt_s = RESP;
         POP_HI:  state_nxt_s = POP_LO;
         POP_LO:  state_nxt_s = CAPTURE;
         CAPTURE: state_nxt_s = RESP;
         RESP:    state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // State, latched request, occupancy count and outputs registered from the next state.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r    <= IDLE;
         id_r       <= 1'b0;
         op_r       <= 1'b0;
         word_r     <= 1'b0;
         wdata_r    <= 16'h0000;
         err_r      <= 1'b0;
         last_gnt_r <= 1'b1;
         count_r    <= '0;
         rdata_r    <= 16'h0000;
         stk_push_r <= 1'b0;
         stk_pop_r  <= 1'b0;
         stk_din_r  <= 8'h00;
         busy_r     <= 1'b0;
         r0_done_r  <= 1'b0;
         r1_done_r  <= 1'b0;
         r0_err_r   <= 1'b0;
         r1_err_r   <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         err_r   <= err_nxt_s;
         if (state_r == IDLE && gnt_valid_s) begin
            id_r       <= gnt_id_s;
            op_r       <= req_op_s;
            word_r     <= req_word_s;
            wdata_r    <= req_wdata_s;
            last_gnt_r <= gnt_id_s;
         end
         if (stk_push_r) begin
            count_r <= count_r + CW'(1);
         end else if (stk_pop_r) begin
            count_r <= count_r - CW'(1);
         end
         // stk_dout is the Stack's registered output, so each byte is taken one cycle after its pop.
         if (state_r == POP_LO) begin
            rdata_r[15:8] <= word_r ? bus.stk_dout : 8'h00;
         end
         if (state_r == CAPTURE) begin
            rdata_r[7:0] <= bus.stk_dout;
         end
         stk_push_r <= (state_nxt_s == PUSH_LO) || (state_nxt_s == PUSH_HI);
         stk_pop_r  <= (state_nxt_s == POP_HI)  || (state_nxt_s == POP_LO);
         case (state_nxt_s)
            PUSH_LO: stk_din_r <= cur_wdata_s[7:0];
            PUSH_HI: stk_din_r <= cur_wdata_s[15:8];
            default: stk_din_r <= 8'h00;
         endcase
         busy_r    <= (state_nxt_s != IDLE);
         r0_done_r <= (state_nxt_s == RESP) && !cur_id_s;
         r1_done_r <= (state_nxt_s == RESP) &&  cur_id_s;
         r0_err_r  <= (state_nxt_s == RESP) && !cur_id_s && err_nxt_s;
         r1_err_r  <= (state_nxt_s == RESP) &&  cur_id_s && err_nxt_s;
      end
   end

   assign bus.r0_done  = r0_done_r;
   assign bus.r1_done  = r1_done_r;
   assign bus.r0_err   = r0_err_r;
   assign bus.r1_err   = r1_err_r;
   assign bus.rdata    = rdata_r;
   assign bus.stk_push = stk_push_r;
   assign bus.stk_pop  = stk_pop_r;
   assign bus.stk_din  = stk_din_r;
   assign bus.busy     = busy_r;
   assign bus.count    = count_r;

   logic unused_s;
   assign unused_s = op_r;
endmodule

// File: tb/tb_stack_access_ctrl.sv
// Directed bench for stack_access_ctrl with a behavioural Stack model and a done-pulse scoreboard.
module tb_stack_access_ctrl;
   localparam int DEPTH = 32;
   localparam int CW    = 6;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   stack_access_if #(.CW(CW)) bus ();

   stack_access_ctrl #(.DEPTH(DEPTH), .CW(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic        id;
      logic        err;
      logic        chk_data;
      logic [15:0] rdata;
   } sb_t;

   sb_t        sb[$];
   logic [7:0] din_log[$];
   int         pop_cnt = 0;
   int         errors  = 0;
   int         checks  = 0;
   int         exp_cnt = 0;

   logic [7:0] mem [0:63];
   int         sp = 0;
   logic [7:0] dout_r = 8'h00;
   assign bus.stk_dout = dout_r;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Stack model: registered top-of-stack output, reset with the system reset.
   always @(posedge clk) begin
      if (!rst) begin
         sp     <= 0;
         dout_r <= 8'h00;
      end else if (bus.stk_push) begin
         mem[sp] <= bus.stk_din;
         sp      <= sp + 1;
      end else if (bus.stk_pop && sp > 0) begin
         dout_r <= mem[sp-1];
         sp     <= sp - 1;
      end
   end

   // Monitor: log stack traffic and score every done pulse.
   always @(negedge clk) begin
      if (rst) begin
         if (bus.stk_push) din_log.push_back(bus.stk_din);
         if (bus.stk_pop)  pop_cnt++;
         if (bus.stk_push || bus.stk_pop) chk("push_pop_excl", {31'd0, bus.stk_push & bus.stk_pop}, 32'd0);
         if (bus.r0_done || bus.r1_done) begin
            if (sb.size() == 0) begin
               chk("unexpected_done", 32'(sb.size()), 32'd1);
            end else begin
               sb_t e;
               e = sb.pop_front();
               chk("done_both", {31'd0, bus.r0_done & bus.r1_done}, 32'd0);
               chk("done_id", {31'd0, bus.r1_done}, {31'd0, e.id});
               chk("done_err", {31'd0, e.id ? bus.r1_err : bus.r0_err}, {31'd0, e.err});
               chk("other_err", {31'd0, e.id ? bus.r0_err : bus.r1_err}, 32'd0);
               if (e.chk_data) chk("rdata", {16'd0, bus.rdata}, {16'd0, e.rdata});
            end
         end
      end
   end

   // One request from one requester; checks latency and the count in the done cycle.
   task automatic req(input logic id, input logic op, input logic word, input logic [15:0] wdata,
                      input logic exp_err, input logic [15:0] exp_rdata);
      sb_t e;
      int  n, lat;
      logic seen;
      e.id = id; e.err = exp_err; e.chk_data = op & ~exp_err; e.rdata = exp_rdata;
      sb.push_back(e);
      lat = exp_err ? 1 : (op ? (word ? 4 : 3) : (word ? 3 : 2));
      if (!exp_err) exp_cnt = op ? exp_cnt - (word ? 2 : 1) : exp_cnt + (word ? 2 : 1);
      if (id) begin
         bus.r1_op = op; bus.r1_word = word; bus.r1_wdata = wdata; bus.r1_valid = 1'b1;
      end else begin
         bus.r0_op = op; bus.r0_word = word; bus.r0_wdata = wdata; bus.r0_valid = 1'b1;
      end
      n = 0;
      seen = 1'b0;
      while (!seen && n < 40) begin
         @(posedge clk); #1;
         n++;
         seen = id ? bus.r1_done : bus.r0_done;
      end
      chk("done_seen", {31'd0, seen}, 32'd1);
      chk("latency", 32'(n), 32'(lat));
      chk("count", {26'd0, bus.count}, 32'(exp_cnt));
      @(posedge clk); #1;
      bus.r0_valid = 1'b0;
      bus.r1_valid = 1'b0;
   endtask

   // Both requesters raised together; each drops valid after its own done cycle.
   task automatic tie(input logic op0, input logic [15:0] wd0, input logic [15:0] rd0,
                      input logic op1, input logic [15:0] wd1, input logic [15:0] rd1);
      sb_t e0, e1;
      int  n;
      logic seen0, seen1;
      e0.id = 1'b0; e0.err = 1'b0; e0.chk_data = op0; e0.rdata = rd0;
      e1.id = 1'b1; e1.err = 1'b0; e1.chk_data = op1; e1.rdata = rd1;
      sb.push_back(e0);
      sb.push_back(e1);
      bus.r0_op = op0; bus.r0_word = 1'b0; bus.r0_wdata = wd0;
      bus.r1_op = op1; bus.r1_word = 1'b0; bus.r1_wdata = wd1;
      bus.r0_valid = 1'b1; bus.r1_valid = 1'b1;
      seen0 = 1'b0; seen1 = 1'b0; n = 0;
      while ((bus.r0_valid || bus.r1_valid) && n < 60) begin
         @(posedge clk); #1;
         n++;
         if (seen0) bus.r0_valid = 1'b0;
         if (seen1) bus.r1_valid = 1'b0;
         if (bus.r0_done) seen0 = 1'b1;
         if (bus.r1_done) seen1 = 1'b1;
      end
      chk("tie_both_done", {30'd0, seen0, seen1}, 32'd3);
      bus.r0_valid = 1'b0;
      bus.r1_valid = 1'b0;
   endtask

   initial begin
      bus.r0_valid = 1'b0; bus.r0_op = 1'b0; bus.r0_word = 1'b0; bus.r0_wdata = 16'h0000;
      bus.r1_valid = 1'b0; bus.r1_op = 1'b0; bus.r1_word = 1'b0; bus.r1_wdata = 16'h0000;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_count", {26'd0, bus.count}, 32'd0);
      chk("rst_rdata", {16'd0, bus.rdata}, 32'd0);
      chk("rst_done", {30'd0, bus.r0_done, bus.r1_done}, 32'd0);
      chk("rst_stk", {30'd0, bus.stk_push, bus.stk_pop}, 32'd0);
      rst = 1'b1;
      @(posedge clk); #1;

      // 1) word push, low byte first
      din_log.delete();
      req(1'b0, 1'b0, 1'b1, 16'hBEEF, 1'b0, 16'h0000);
      chk("push_bytes", 32'(din_log.size()), 32'd2);
      if (din_log.size() == 2) begin
         chk("push_lo", {24'd0, din_log[0]}, 32'h0000_00EF);
         chk("push_hi", {24'd0, din_log[1]}, 32'h0000_00BE);
      end

      // 2) word pop
      pop_cnt = 0;
      req(1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 16'hBEEF);
      chk("pop_cycles", 32'(pop_cnt), 32'd2);

      // 3) underflow on an empty stack
      pop_cnt = 0;
      req(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000);
      chk("underflow_no_pop", 32'(pop_cnt), 32'd0);

      // 4) ties: r0 first, r1 next; a later tie goes to r0 again
      tie(1'b0, 16'h0011, 16'h0000, 1'b0, 16'h0022, 16'h0000);
      exp_cnt = 2;
      chk("tie_count", {26'd0, bus.count}, 32'(exp_cnt));
      chk("tie_top", {24'd0, mem[sp-1]}, 32'h0000_0022);
      tie(1'b1, 16'h0000, 16'h0022, 1'b1, 16'h0000, 16'h0011);
      exp_cnt = 0;
      chk("tie2_count", {26'd0, bus.count}, 32'd0);

      // 5) fill to 31, then boundary pushes
      for (int i = 0; i < 15; i++) req(1'b0, 1'b0, 1'b1, 16'(16'h1000 + i), 1'b0, 16'h0000);
      req(1'b1, 1'b0, 1'b0, 16'h0033, 1'b0, 16'h0000);
      chk("fill_count", {26'd0, bus.count}, 32'd31);
      req(1'b0, 1'b0, 1'b1, 16'hAAAA, 1'b1, 16'h0000);
      req(1'b0, 1'b0, 1'b0, 16'h005A, 1'b0, 16'h0000);
      chk("full_count", {26'd0, bus.count}, 32'd32);
      chk("full_top", {24'd0, mem[sp-1]}, 32'h0000_005A);
      req(1'b0, 1'b0, 1'b0, 16'h0066, 1'b1, 16'h0000);
      req(1'b1, 1'b0, 1'b1, 16'h0077, 1'b1, 16'h0000);

      // 6) reset in the POP_LO cycle of a word pop aborts it without a done pulse
      bus.r0_op = 1'b1; bus.r0_word = 1'b1; bus.r0_valid = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("abort_busy_before", {31'd0, bus.busy}, 32'd1);
      chk("abort_pop_lo", {31'd0, bus.stk_pop}, 32'd1);
      rst = 1'b0;
      bus.r0_valid = 1'b0;
      @(posedge clk); #1;
      chk("abort_busy", {31'd0, bus.busy}, 32'd0);
      chk("abort_count", {26'd0, bus.count}, 32'd0);
      rst = 1'b1;
      exp_cnt = 0;
      repeat (3) @(posedge clk);
      #1;
      req(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000);

      // count==1: word pop errors, byte pop succeeds
      req(1'b1, 1'b0, 1'b0, 16'h00C3, 1'b0, 16'h0000);
      req(1'b0, 1'b1, 1'b1, 16'h0000, 1'b1, 16'h0000);
      req(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h00C3);

      repeat (3) @(posedge clk);
      #1;
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
